uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver with a show-ahead receive FIFO. Samples the
//  board ser_rx pin and presents bytes to the CPU data_path's memory-mapped
//  UART port through the rx_data/rx_valid/rx_re handshake.
//  Receive-side counterpart of the uart_tx path already driven by data_path.
// PARAMETERS
//  CLK_DIV     868  clk cycles per bit (100 MHz / 115200); legal range >= 4
//  FIFO_DEPTH  16   receive FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  resetn      in   1   asynchronous, active-low reset
//  ser_rx      in   1   serial input, idle high, asynchronous to clk
//  rx_re       in   1   pop request from data_path; honoured only when rx_valid=1
//  rx_data     out  8   FIFO head byte; valid while rx_valid=1
//  rx_valid    out  1   FIFO not empty
//  rx_count    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  rx_overrun  out  1   sticky: byte dropped because FIFO full; cleared by next accepted pop
//  frame_err   out  1   one-cycle pulse: stop bit sampled low
//  parity_err  out  1   one-cycle pulse: parity mismatch (0 without UART_RX_PARITY_EN)
// BEHAVIOUR
//  Reset: all outputs 0, rx_data 8'h00, FSM IDLE, FIFO empty; synchroniser flops reset to 1.
//  ser_rx passes a 2-flop synchroniser (2 cycles of latency) before any use.
//  FSM IDLE -> START on synchronised falling edge; bit counter loads CLK_DIV/2-1.
//  START: at mid-bit, line low -> DATA; line high -> IDLE (glitch rejected, no error).
//  DATA: sample every CLK_DIV cycles, 8 bits, LSB first, into shift register.
//  (PARITY when enabled) -> STOP: sample mid-bit.
//   stop=1 -> push byte in the same cycle (write lands next edge), then IDLE.
//   stop=0 -> frame_err pulse, byte discarded -> BREAK; BREAK waits for line=1, then IDLE.
//  Bit-timer width $clog2(CLK_DIV); reloads CLK_DIV-1 on each expiry; no cumulative drift.
//  rx_valid rises the cycle after the stop-bit sample; rx_data = head (show-ahead).
//  Pop: rx_re && rx_valid -> head advances next edge. rx_re while empty: ignored, no underflow.
//  Push while full: byte dropped, rx_overrun set, FIFO contents unchanged.
//  Simultaneous push+pop when full: both performed, no overrun, count unchanged.
//  Simultaneous push+pop when empty: push lands, pop ignored (rx_valid was 0).
//  Pointers wrap modulo FIFO_DEPTH; full/empty by count register, not pointer compare.
//  Reset mid-frame: partial byte lost, FIFO flushed, FSM to IDLE immediately.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame 8E1; PARITY state after DATA checks even parity;
//   mismatch -> parity_err pulse, byte discarded, STOP still sampled (frame_err independent).
//  Undefined: frame 8N1, no PARITY state, parity_err tied 0.
// STRUCTURE
//  uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK), DEFAULT_CLK_DIV=868,
//   DATA_BITS=8 constant.
//  One sub-module: uart_rx_fifo (synchronous show-ahead FIFO, DEPTH param, count output).
//  Top holds synchroniser, bit timer, bit index, shift register, FSM.
// TESTING (bench CLK_DIV=16, FIFO_DEPTH=4)
//  Send 8'hA5 8N1 -> rx_valid after stop mid-sample +1, rx_data=A5, rx_count=1; rx_re -> count 0.
//  Send 8'h00, 8'hFF, 8'h55 back-to-back, no pop -> popped in order 00,FF,55; no errors.
//  Send 5 bytes (01..05), no pop -> FIFO holds 01..04, rx_overrun=1; pop once -> overrun clears.
//  Low glitch of 4 cycles on idle line -> FSM returns IDLE, no push, no error flags.
//  Byte 8'h3C with stop bit forced 0 -> frame_err one pulse, count unchanged, next 8'h7E received.
//  Assert resetn low mid-DATA with 2 bytes queued -> rx_valid=0, count 0; next byte received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive path.
package uart_pkg;

  localparam int DEFAULT_CLK_DIV = 868;
  localparam int DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead receive FIFO; head byte is visible on rd_data while valid.
// Occupancy is tracked by a count register and drives the full/empty decisions.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = rd_en && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !do_push) overrun <= 1'b1;
      else if (do_pop)       overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and show-ahead receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking; default is 8N1.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ser_rx,
  input  logic                        rx_re,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        rx_overrun,
  output logic                        frame_err,
  output logic                        parity_err
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV/2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);

  logic                 sync_p0;
  logic                 sync_p1;
  logic                 rx_prev;
  logic                 rx_s;
  logic                 fall;

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [TW-1:0]        bit_tmr;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tick;
  logic                 push;
  logic                 frm_bad;

  // Stage p0/p1: metastability synchroniser, idle-high through reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_p0 <= ser_rx;
      sync_p1 <= sync_p0;
      rx_prev <= sync_p1;
    end
  end

  assign rx_s = sync_p1;
  assign fall = rx_prev && !rx_s;
  assign tick = (bit_tmr == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_mis;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    frm_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis   = 1'b0;
`endif
    case (state)
      IDLE:  if (fall) state_nxt = START;
      // A start bit that is high again at mid-bit was a glitch; drop it silently.
      START: if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick && bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_mis   = (rx_s != even_parity(shift_q));
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
            state_nxt = IDLE;
          end else begin
            frm_bad   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timer reloads a full bit period on every expiry so sample points never drift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_tmr   <= HALF_LOAD;
      bit_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= frm_bad;
      if (state == IDLE || state == BREAK) bit_tmr <= HALF_LOAD;
      else if (tick)                       bit_tmr <= FULL_LOAD;
      else                                 bit_tmr <= bit_tmr - 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (tick)      bit_idx <= bit_idx + 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_mis;
      if (state == START)                par_bad <= 1'b0;
      else if (state == PARITY && tick)  par_bad <= par_mis;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (state == DATA && tick) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rx_re),
    .rd_data (rx_data),
    .valid   (rx_valid),
    .count   (rx_count),
    .overrun (rx_overrun)
  );

endmodule
